// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |B| > |A|.
module div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kill,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   DivSel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] DivRes,
    output logic         busy
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  dvd;     // dividend magnitude shifting out, quotient bits shifting in
    logic [N-1:0]  rem;
    logic [N-1:0]  mag_b;
    logic          rem_sel, neg_q, neg_r;

    logic          accept, is_signed, div_zero, ovf, early, special;
    logic [N-1:0]  mag_a_in, mag_b_in, spec_q, spec_r, spec_res;
    logic [N:0]    r_shift, r_sub;
    logic          ge, last;
    logic [N-1:0]  r_step, q_step, q_fin, r_fin, res_fin;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready && !kill;
    assign is_signed = ~DivSel[0];

    // Magnitudes of the most negative value wrap to 2^(N-1), which is correct as unsigned.
    assign mag_a_in = (is_signed && A[N-1]) ? -A : A;
    assign mag_b_in = (is_signed && B[N-1]) ? -B : B;

    assign div_zero = (B == '0);
    assign ovf      = is_signed && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early    = (mag_b_in > mag_a_in);
`else
    assign early    = 1'b0;
`endif
    assign special  = div_zero || ovf || early;

    always_comb begin
        spec_q = '0;
        spec_r = A;
        if (div_zero) begin
            spec_q = '1;
        end else if (ovf) begin
            spec_q = {1'b1, {(N-1){1'b0}}};
            spec_r = '0;
        end
    end
    assign spec_res = DivSel[1] ? spec_r : spec_q;

    // Partial remainder stays below 2^N, so the borrow of the N+1 bit subtraction is the compare.
    assign r_shift = {rem, dvd[N-1]};
    assign r_sub   = r_shift - {1'b0, mag_b};
    assign ge      = ~r_sub[N];
    assign r_step  = ge ? r_sub[N-1:0] : r_shift[N-1:0];
    assign q_step  = {dvd[N-2:0], ge};
    assign last    = (cnt == CW'(N-1));

    assign q_fin   = neg_q ? -q_step : q_step;
    assign r_fin   = neg_r ? -r_step : r_step;
    assign res_fin = rem_sel ? r_fin : q_fin;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            DivRes    <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            dvd       <= '0;
            rem       <= '0;
            mag_b     <= '0;
            rem_sel   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (kill) begin
                out_valid <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        dvd     <= mag_a_in;
                        mag_b   <= mag_b_in;
                        rem     <= '0;
                        cnt     <= '0;
                        rem_sel <= DivSel[1];
                        neg_q   <= is_signed && (A[N-1] ^ B[N-1]);
                        neg_r   <= is_signed && A[N-1];
                        if (special) begin
                            DivRes    <= spec_res;
                            out_valid <= 1'b1;
                        end
                    end
                    CALC: begin
                        rem <= r_step;
                        dvd <= q_step;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            DivRes    <= res_fin;
                            out_valid <= 1'b1;
                            cnt       <= '0;
                        end
                    end
                    DONE: if (out_ready) out_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
